mod25519_reduce_seq: RTL and testbench

- Multi-cycle modular reducer for the Curve25519 field, p = 2^255 - 19.
- Sits directly downstream of the 255-bit DSP/compressor multiplier. It consumes the 510-bit unreduced product and returns the canonical residue in [0, p-1].
- Uses folding by 19 with shift-add logic (no DSP) and a final conditional subtract.
- Has a valid/ready handshake on both sides, so the ECC point-arithmetic controller can stall it.

---
 rtl/ecc25519_pkg.sv | 26 ++
 rtl/mod25519_fold.sv | 24 ++
 rtl/mod25519_reduce_seq.sv | 126 ++++++++++++
 tb/tb_mod25519_reduce_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc25519_pkg.sv
// ecc25519_pkg
// Shared constants and types for the Curve25519 field arithmetic blocks.
//   W        : field width (255), p = 2^W - C
//   C        : fold constant (19)
//   PW       : unreduced product width (2*W = 510)
//   P_25519  : the field modulus p as a W-bit constant
//   state_t  : reducer FSM state encoding (3 bits)
package ecc25519_pkg;

  localparam int W  = 255;
  localparam int C  = 19;
  localparam int PW = 2 * W;

  // 2^255 - 19: 250 ones followed by 0b01101 (0x...ffed).
  localparam logic [W-1:0] P_25519 = {{(W-5){1'b1}}, 5'b01101};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD1 = 3'd1,
    FOLD2 = 3'd2,
    FOLD3 = 3'd3,
    CSUB  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mod25519_fold.sv
// mod25519_fold
// Combinational fold step sum = lo + 19*hi, built from shifts and adds only.
// The output is wide enough that no carry is ever dropped.
//   lo_i  [LO_W-1:0]  : low part of the operand (below 2^W)
//   hi_i  [HI_W-1:0]  : high part of the operand (multiplied by 19)
//   sum_o [OUT_W-1:0] : lo_i + 19*hi_i
module mod25519_fold #(
  parameter int LO_W  = 255,
  parameter int HI_W  = 255,
  parameter int OUT_W = ((LO_W > HI_W + 5) ? LO_W : HI_W + 5) + 1
) (
  input  logic [LO_W-1:0]  lo_i,
  input  logic [HI_W-1:0]  hi_i,
  output logic [OUT_W-1:0] sum_o
);

  logic [OUT_W-1:0] hi_ext;

  assign hi_ext = OUT_W'(hi_i);

  // 19*hi = 16*hi + 2*hi + hi
  assign sum_o = OUT_W'(lo_i) + (hi_ext << 4) + (hi_ext << 1) + hi_ext;

endmodule

// File: rtl/mod25519_reduce_seq.sv
// mod25519_reduce_seq
// Multi-cycle reducer of a 510-bit product modulo p = 2^255 - 19. Three fold
// passes through one shared fold unit, then a single conditional subtract,
// giving the canonical residue in [0, p-1]. Valid/ready on both sides.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   prod_in   : unreduced product, any 510-bit value
//   in_valid  : prod_in valid
//   in_ready  : block can accept (IDLE only)
//   res_out   : canonical residue
//   out_valid : res_out valid (DONE only)
//   out_ready : consumer accepts res_out
//   busy      : high whenever not IDLE
module mod25519_reduce_seq #(
  parameter int W  = ecc25519_pkg::W,
  parameter int C  = ecc25519_pkg::C,
  parameter int PW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] prod_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  res_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  import ecc25519_pkg::*;

  localparam int HW = PW - W;                               // high-half width
  localparam int TW = ((W > HW + 5) ? W : HW + 5) + 1;      // first-fold width (261)
  localparam logic [W-1:0] P_MOD = {W{1'b1}} - W'(C - 1);   // 2^W - C

  state_t          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;
  logic [TW-1:0]   t_q, t_d;
  logic [W-1:0]    res_q, res_d;

  logic [W-1:0]    fold_lo;
  logic [HW-1:0]   fold_hi;
  logic [TW-1:0]   fold_sum;
  logic            ge_p;

  mod25519_fold #(
    .LO_W  (W),
    .HI_W  (HW),
    .OUT_W (TW)
  ) u_fold (
    .lo_i  (fold_lo),
    .hi_i  (fold_hi),
    .sum_o (fold_sum)
  );

  // No borrow from t3 - p exactly when t3 >= p. After three folds t3 < 2p,
  // so one subtract is enough; the low W bits of the difference are the result.
  assign ge_p = (t_q[W:0] >= {1'b0, P_MOD});

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    t_d     = t_q;
    res_d   = res_q;
    // The shared fold unit sees x by default; FOLD2/FOLD3 steer it onto t.
    fold_lo = x_q[W-1:0];
    fold_hi = x_q[PW-1:W];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = prod_in;
          state_d = FOLD1;
        end
      end
      FOLD1: begin
        t_d     = fold_sum;
        state_d = FOLD2;
      end
      FOLD2: begin
        fold_lo = t_q[W-1:0];
        fold_hi = HW'(t_q[TW-1:W]);
        t_d     = fold_sum;
        state_d = FOLD3;
      end
      FOLD3: begin
        // Only bit W of t2 can be set above the low field, so hi is 0 or 1.
        fold_lo = t_q[W-1:0];
        fold_hi = HW'(t_q[W]);
        t_d     = fold_sum;
        state_d = CSUB;
      end
      CSUB: begin
        res_d   = ge_p ? (t_q[W-1:0] - P_MOD) : t_q[W-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      t_q     <= t_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign res_out   = res_q;

endmodule

// File: tb/tb_mod25519_reduce_seq.sv
// tb_mod25519_reduce_seq
// Self-checking bench for mod25519_reduce_seq: reset state, directed corner
// values with latency, backpressure, mid-operation reset, and a randomized
// back-to-back stream checked in order against prod mod p.
module tb_mod25519_reduce_seq;
  import ecc25519_pkg::*;

  localparam int N_RAND = 3000;
  localparam int N_PROD = 1000;
  localparam int N_STREAM = N_RAND + N_PROD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] prod_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  res_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic         cons_done = 1'b0;

  mod25519_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (prod_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_out   (res_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular remainder of the full product.
  function automatic logic [W-1:0] ref_mod(input logic [PW-1:0] v);
    logic [PW-1:0] pp;
    logic [PW-1:0] r;
    pp = PW'(P_25519);
    r  = v % pp;
    return r[W-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_wide();
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v = (v << 32) | PW'($urandom());
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rand_field();
    logic [PW-1:0] v;
    v = rand_wide();
    return v[W-1:0];
  endfunction

  // One reduction with out_ready held high; checks latency and result.
  task automatic run_directed(input string tag, input logic [PW-1:0] p_in, input logic [W-1:0] expv);
    int lat;
    check({tag, "_in_ready"}, PW'(in_ready), PW'(1));
    prod_in   = p_in;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, PW'(lat), PW'(4));
    check({tag, "_res"}, PW'(res_out), PW'(expv));
    $display("directed %s: prod=%0h res=%0h latency=%0d", tag, p_in, res_out, lat);
    @(posedge clk); #1;
    check({tag, "_released"}, PW'({out_valid, in_ready}), PW'(2'b01));
  endtask

  initial begin
    logic [PW-1:0] d_prod[7];
    logic [W-1:0]  d_exp[7];
    string         d_tag[7];
    logic [PW-1:0] one;
    logic [PW-1:0] pm1;
    logic [PW-1:0] pr;
    logic [W-1:0]  e;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            lat;
    int            seen;

    one = PW'(1);
    pm1 = PW'(P_25519) - one;
    d_prod[0] = '0;                    d_exp[0] = '0;                     d_tag[0] = "zero";
    d_prod[1] = PW'(P_25519);          d_exp[1] = '0;                     d_tag[1] = "p";
    d_prod[2] = one << 255;            d_exp[2] = W'(19);                 d_tag[2] = "two255";
    d_prod[3] = (one << 255) - one;    d_exp[3] = W'(18);                 d_tag[3] = "two255m1";
    d_prod[4] = pm1;                   d_exp[4] = P_25519 - W'(1);        d_tag[4] = "pm1";
    d_prod[5] = pm1 * pm1;             d_exp[5] = W'(1);                  d_tag[5] = "pm1_sq";
    d_prod[6] = '1;                    d_exp[6] = W'(360);                d_tag[6] = "all_ones";

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_res_out", PW'(res_out), PW'(0));
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_in_ready", PW'(in_ready), PW'(1));
    $display("reset: out_valid=%0b busy=%0b in_ready=%0b res=%0h", out_valid, busy, in_ready, res_out);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed corner values
    for (int i = 0; i < 7; i++) begin
      run_directed(d_tag[i], d_prod[i], d_exp[i]);
    end

    // Backpressure: hold DONE for 10 cycles while in_valid toggles.
    pr = rand_wide();
    e  = ref_mod(pr);
    prod_in   = pr;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", PW'(lat), PW'(4));
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      prod_in  = rand_wide();
      @(posedge clk); #1;
      check("bp_res_stable", PW'(res_out), PW'(e));
      check("bp_hold", PW'({out_valid, in_ready, busy}), PW'(3'b101));
    end
    $display("backpressure: prod=%0h res=%0h held 10 cycles", pr, res_out);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", PW'({out_valid, in_ready}), PW'(2'b01));
    @(posedge clk); #1;
    check("bp_no_stray_accept", PW'(busy), PW'(0));

    // Reset while in FOLD2
    pr = rand_wide() | (one << 400);
    prod_in   = pr;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;              // accepted, now FOLD1
    in_valid = 1'b0;
    @(posedge clk); #1;              // now FOLD2
    check("midrst_busy_before", PW'(busy), PW'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", PW'(out_valid), PW'(0));
    check("midrst_res_out", PW'(res_out), PW'(0));
    check("midrst_busy", PW'(busy), PW'(0));
    check("midrst_in_ready", PW'(in_ready), PW'(1));
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_stale", PW'(seen), PW'(0));
    $display("mid-op reset: prod=%0h aborted, stale outputs=%0d", pr, seen);

    // Randomized back-to-back stream with random out_ready
    fork
      begin : producer
        logic acc;
        int   guard;
        for (int i = 0; i < N_STREAM; i++) begin
          if (i < N_RAND) begin
            pr = rand_wide();
          end else begin
            a  = rand_field();
            b  = rand_field();
            pr = PW'(a) * PW'(b);
          end
          prod_in  = pr;
          in_valid = 1'b1;
          acc   = 1'b0;
          guard = 0;
          while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 1);
            guard++;
          end
          if (!acc) begin
            check("stream_accept_timeout", PW'(guard), PW'(0));
          end else begin
            exp_q.push_back(ref_mod(pr));
          end
        end
        in_valid = 1'b0;
        while (!cons_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
      begin : consumer
        int got;
        int guard;
        logic [W-1:0] ev;
        got   = 0;
        guard = 0;
        while (got < N_STREAM && guard < 80000) begin
          @(negedge clk);
          guard++;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("stream_unexpected_output", PW'(res_out), PW'(0) - PW'(1));
            end else begin
              ev = exp_q.pop_front();
              check("stream_res", PW'(res_out), PW'(ev));
              $display("stream %0d: res=%0h", got, res_out);
              got++;
            end
            // Wait for the handshake edge so one result is not counted twice.
            @(posedge clk);
          end
        end
        check("stream_count", PW'(got), PW'(N_STREAM));
        cons_done = 1'b1;
      end
    join
    check("stream_queue_empty", PW'(exp_q.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
